// File: rtl/hex_display_scheduler.sv
// Time-shares one external seven-segment decoder across six digits: a held value is
// scanned one nibble per two cycles and each decoded pattern is latched per digit.
module hex_display_scheduler #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  input  logic                      load_lz_en,
  output logic [3:0]                dec_hex,
  input  logic [6:0]                dec_seg,
  output logic [6:0]                hex0,
  output logic [6:0]                hex1,
  output logic [6:0]                hex2,
  output logic [6:0]                hex3,
  output logic [6:0]                hex4,
  output logic [6:0]                hex5,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned VW       = 4 * NUM_DIGITS;
  localparam int unsigned IW       = 3;
  localparam int unsigned CW       = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam bit          REFRESH_EN = (REFRESH_CYCLES != 0);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF      = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [3:0]            r_dec_hex;
  logic                  r_busy;
  logic                  r_done;
  logic [VW-1:0]         r_held_value;
  logic [NUM_DIGITS-1:0] r_held_blank;
  logic                  r_held_lz_en;
  logic [CW-1:0]         r_refresh_cnt;
  logic [6:0]            r_hex [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic                  w_digit_dark;
  logic [3:0]            w_nibble;

  // A digit is a leading zero when it and every more significant nibble are zero; HEX0 never is.
  always_comb begin
    w_lz_blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      w_lz_blank[k] = r_held_lz_en && ((r_held_value >> (4 * k)) == '0);
    end
  end

  assign w_digit_dark = r_held_blank[r_idx] | w_lz_blank[r_idx];
  assign w_nibble     = r_held_value[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_dec_hex     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_held_value  <= '0;
      r_held_blank  <= '0;
      r_held_lz_en  <= 1'b0;
      r_refresh_cnt <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_hex[k] <= SEG_OFF;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_held_value  <= load_value;
            r_held_blank  <= load_blank;
            r_held_lz_en  <= load_lz_en;
            r_refresh_cnt <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end else if (REFRESH_EN && (r_refresh_cnt == REFRESH_LAST)) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end else begin
            r_refresh_cnt <= r_refresh_cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          r_dec_hex <= w_nibble;
          r_state   <= S_LATCH;
        end
        S_LATCH: begin
          r_hex[r_idx] <= w_digit_dark ? SEG_OFF : dec_seg;
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == S_IDLE) && !rst;
  assign dec_hex    = r_dec_hex;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hex0       = r_hex[0];
  assign hex1       = r_hex[1];
  assign hex2       = r_hex[2];
  assign hex3       = r_hex[3];
  assign hex4       = r_hex[4];
  assign hex5       = r_hex[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: one instance without refresh for the load vectors,
// one with a short refresh period for re-scan and mid-scan reset sequences.
module tb_hex_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ld_value;
  logic [5:0]  ld_blank;
  logic        ld_lz;

  logic            a_valid, a_ready, a_busy, a_done;
  logic [3:0]      a_dec_hex;
  logic [6:0]      a_dec_seg;
  logic [5:0][6:0] a_hex;

  logic            b_valid, b_ready, b_busy, b_done;
  logic [3:0]      b_dec_hex;
  logic [6:0]      b_dec_seg;
  logic [5:0][6:0] b_hex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Reference active-low decoder standing in for the external part.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign a_dec_seg = seg_of(a_dec_hex);
  assign b_dec_seg = seg_of(b_dec_hex);

  hex_display_scheduler #(.NUM_DIGITS(6), .REFRESH_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_ready(a_ready),
    .load_value(ld_value), .load_blank(ld_blank), .load_lz_en(ld_lz),
    .dec_hex(a_dec_hex), .dec_seg(a_dec_seg),
    .hex0(a_hex[0]), .hex1(a_hex[1]), .hex2(a_hex[2]),
    .hex3(a_hex[3]), .hex4(a_hex[4]), .hex5(a_hex[5]),
    .busy(a_busy), .done(a_done)
  );

  hex_display_scheduler #(.NUM_DIGITS(6), .REFRESH_CYCLES(20)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_ready(b_ready),
    .load_value(ld_value), .load_blank(ld_blank), .load_lz_en(ld_lz),
    .dec_hex(b_dec_hex), .dec_seg(b_dec_seg),
    .hex0(b_hex[0]), .hex1(b_hex[1]), .hex2(b_hex[2]),
    .hex3(b_hex[3]), .hex4(b_hex[4]), .hex5(b_hex[5]),
    .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [23:0] value;
    logic [5:0]  blank;
    logic        lz;
    logic [41:0] hex;   // {hex5, ..., hex0}
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Offer a value to instance A and return in the cycle after the accepting edge.
  task automatic load_a(input logic [23:0] v, input logic [5:0] b, input logic lz);
    int w;
    ld_value = v; ld_blank = b; ld_lz = lz; a_valid = 1'b1; w = 0;
    while (!a_ready && w < 50) begin tick(); w++; end
    check("a_accept_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic load_b(input logic [23:0] v, input logic [5:0] b, input logic lz);
    int w;
    ld_value = v; ld_blank = b; ld_lz = lz; b_valid = 1'b1; w = 0;
    while (!b_ready && w < 50) begin tick(); w++; end
    check("b_accept_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int n;
    logic [23:0] seq;
    load_a(vecs[i].value, vecs[i].blank, vecs[i].lz);
    check($sformatf("v%0d_busy", i), 64'(a_busy), 64'd1);
    n = 1; seq = '0;
    while (!a_done && n < 40) begin
      tick(); n++;
      if ((n % 2) == 0 && n <= 12) seq[(2 * n - 4) +: 4] = a_dec_hex;
    end
    check($sformatf("v%0d_done_latency", i), 64'(n), 64'd13);
    check($sformatf("v%0d_dec_hex_seq", i), 64'(seq), 64'(vecs[i].value));
    check($sformatf("v%0d_ready_at_done", i), 64'(a_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("v%0d_hex%0d", i, k), 64'(a_hex[k]), 64'(vecs[i].hex[7 * k +: 7]));
    end
  endtask

  initial begin
    int n, m, pulses;
    logic [41:0] b_exp;

    vecs[0] = '{24'h12ABEF, 6'b000000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h03, 7'h06, 7'h0E}};
    vecs[1] = '{24'h000050, 6'b000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{24'h777777, 6'b101010, 1'b0, {7'h7F, 7'h78, 7'h7F, 7'h78, 7'h7F, 7'h78}};
    vecs[4] = '{24'h000050, 6'b000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h40}};
    vecs[5] = '{24'h090000, 6'b000001, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h40, 7'h40, 7'h7F}};
    vecs[6] = '{24'hF00000, 6'b000000, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    ld_value = '0; ld_blank = '0; ld_lz = 1'b0;
    repeat (3) tick();
    check("rst_ready_low", 64'(a_ready), 64'd0);
    check("rst_hex_all_off", 64'(a_hex), 64'({6{7'h7F}}));
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_dec_hex", 64'(a_dec_hex), 64'd0);

    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(a_ready), 64'd1);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (a_done) pulses++;
    end
    check("idle_no_done", 64'(pulses), 64'd0);
    check("idle_hex_off", 64'(a_hex), 64'({6{7'h7F}}));

    for (int i = 0; i < 7; i++) run_vec(i);

    // Load held high from the third scan cycle is taken only at the done cycle.
    load_a(24'h123456, 6'b000000, 1'b0);
    n = 1;
    tick(); tick(); n = 3;
    ld_value = 24'h654321; a_valid = 1'b1;
    check("b2b_ready_busy", 64'(a_ready), 64'd0);
    while (!a_done && n < 40) begin tick(); n++; end
    check("b2b_first_latency", 64'(n), 64'd13);
    check("b2b_first_hex0", 64'(a_hex[0]), 64'(7'h02));
    check("b2b_first_hex5", 64'(a_hex[5]), 64'(7'h79));
    check("b2b_ready_at_done", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    m = 1;
    tick(); tick(); m = 3;
    check("b2b_mid_hex0_new", 64'(a_hex[0]), 64'(7'h79));
    check("b2b_mid_hex1_old", 64'(a_hex[1]), 64'(7'h12));
    while (!a_done && m < 40) begin tick(); m++; end
    check("b2b_second_latency", 64'(m), 64'd13);
    check("b2b_second_hex0", 64'(a_hex[0]), 64'(7'h79));
    check("b2b_second_hex5", 64'(a_hex[5]), 64'(7'h02));

    // Refresh instance: automatic re-scan after 20 idle cycles, then reset mid-scan.
    b_exp = {7'h30, 7'h46, 7'h40, 7'h12, 7'h21, 7'h10};
    load_b(24'h3C05D9, 6'b000000, 1'b1);
    n = 1;
    while (!b_done && n < 40) begin tick(); n++; end
    check("ref_load_latency", 64'(n), 64'd13);
    check("ref_load_hex", 64'(b_hex), 64'(b_exp));
    m = 0;
    while (!b_busy && m < 60) begin tick(); m++; end
    check("ref_idle_cycles", 64'(m), 64'd20);
    n = 0;
    while (!b_done && n < 40) begin tick(); n++; end
    check("ref_rescan_latency", 64'(n), 64'd12);
    check("ref_rescan_hex", 64'(b_hex), 64'(b_exp));
    m = 0;
    while (!b_busy && m < 60) begin tick(); m++; end
    check("ref_second_idle", 64'(m), 64'd20);
    repeat (7) tick();
    check("ref_busy_latch3", 64'(b_busy), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_hex_off", 64'(b_hex), 64'({6{7'h7F}}));
    check("midrst_done", 64'(b_done), 64'd0);
    check("midrst_busy", 64'(b_busy), 64'd0);
    check("midrst_ready", 64'(b_ready), 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (b_done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    check("midrst_ready_after", 64'(b_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
